// File: rtl/phase_meter.sv
// phase_meter: measures the reference period and the delay from each reference
// rising edge to the first signal rising edge that follows it.
//
// Ports:
//   clk          fast clock; all logic runs on its rising edge
//   rst_n        synchronous active-low reset
//   ref_in       asynchronous reference square wave
//   sig_in       asynchronous measured square wave
//   phase_cnt    cycles from a reference edge to the first signal edge (last period)
//   period_cnt   cycles between the last two reference edges
//   sig_missing  last completed period had no signal edge
//   valid        one-cycle strobe; all results update together
//   overflow     one-cycle strobe; period counter saturated, measurement dropped
module phase_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ref_in,
  input  logic             sig_in,
  output logic [CNT_W-1:0] phase_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             sig_missing,
  output logic             valid,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("phase_meter: SYNC_STAGES must be 2 or 3");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ref_sync;
  logic [SYNC_STAGES-1:0] sig_sync;
  logic                   ref_d;
  logic                   sig_d;
  logic                   rise_ref;
  logic                   rise_sig;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       phase_cap;
  logic                   seen;

  // Input synchronisers plus one delay register each for edge detection.
  // Both paths are identical so the measured phase carries no bias.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_sync <= '0;
      sig_sync <= '0;
      ref_d    <= 1'b0;
      sig_d    <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      sig_sync <= {sig_sync[SYNC_STAGES-2:0], sig_in};
      ref_d    <= ref_sync[SYNC_STAGES-1];
      sig_d    <= sig_sync[SYNC_STAGES-1];
    end
  end

  assign rise_ref = ref_sync[SYNC_STAGES-1] & ~ref_d;
  assign rise_sig = sig_sync[SYNC_STAGES-1] & ~sig_d;

  // Measurement FSM: counts cycles since the last reference edge, captures the
  // first signal edge of each period and publishes results on the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      phase_cap   <= '0;
      seen        <= 1'b0;
      phase_cnt   <= '0;
      period_cnt  <= '0;
      sig_missing <= 1'b0;
      valid       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      valid    <= 1'b0;
      overflow <= 1'b0;
      case (state)
        IDLE: begin
          // First edge only arms; there is no open period to report.
          if (rise_ref) begin
            cnt   <= CNT_ONE;
            seen  <= 1'b0;
            state <= MEASURE;
          end else begin
            cnt <= '0;
          end
        end
        MEASURE: begin
          if (rise_ref) begin
            period_cnt <= cnt;
            if (seen) begin
              phase_cnt   <= phase_cap;
              sig_missing <= 1'b0;
            end else begin
              phase_cnt   <= cnt;
              sig_missing <= 1'b1;
            end
            valid <= 1'b1;
            cnt   <= CNT_ONE;
            // A coincident signal edge opens the new period with zero phase.
            seen  <= rise_sig;
            if (rise_sig) begin
              phase_cap <= '0;
            end
          end else if (cnt == CNT_MAX) begin
            // Period too long to represent: drop it and wait to re-arm.
            overflow <= 1'b1;
            cnt      <= '0;
            seen     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (rise_sig && !seen) begin
              phase_cap <= cnt;
              seen      <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
